// File: rtl/yuv422_pack64.sv
// yuv422_pack64: packs 16-bit YUV422 pixels into 64-bit words through a show-ahead FIFO,
// tagging start-of-frame / end-of-line and padding each line's final partial word.
module yuv422_pack64 #(
  parameter int          P_FIFO_DEPTH = 8,
  parameter logic [15:0] P_PAD        = 16'h1080
) (
  input  logic        i_sclk,
  input  logic        i_rst_n,
  input  logic [15:0] i_data,
  input  logic        i_vsync,
  input  logic        i_hsync,
  input  logic        i_de,
  output logic [63:0] o_wdata,
  output logic        o_sof,
  output logic        o_eol,
  output logic        o_wvalid,
  input  logic        i_wready,
  output logic        o_ovf,
  input  logic        i_ovf_clr,
  output logic [11:0] o_line_pix
);
  localparam int AW = $clog2(P_FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;
  state_t state;
  logic [15:0] data_d;
  logic de_d, vsync_d, sof_arm;
  logic [1:0] cnt;
  logic [63:0] part, word;
  logic [11:0] lcnt, lnext;
  logic [65:0] mem [P_FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic last, vs_rise, push_req, pop, full, drop, push;
  logic unused_hsync;
  assign unused_hsync = i_hsync;
  assign last = de_d & ~i_de;
  assign vs_rise = i_vsync & ~vsync_d;
  assign push_req = state == ACTIVE & ~vs_rise & de_d & (cnt == 2'd3 | last);
  assign pop = o_wvalid & i_wready;
  assign full = count == (AW+1)'(P_FIFO_DEPTH);
  assign drop = push_req & full & ~pop;
  assign push = push_req & ~drop;
  assign lnext = lcnt == 12'hFFF ? lcnt : lcnt + 12'd1;
  assign o_wvalid = count != '0;
  assign {o_sof, o_eol, o_wdata} = mem[rptr];
  // lanes below cnt come from the partial word, the current pixel lands in lane cnt
  always_comb begin
    word = {4{P_PAD}};
    for (int i = 0; i < 4; i++)
      word[16*i +: 16] = i < int'(cnt) ? part[16*i +: 16] : i == int'(cnt) ? data_d : P_PAD;
  end
  always_ff @(posedge i_sclk)
    if (push) mem[wptr] <= {sof_arm, last, word};
  always_ff @(posedge i_sclk)
    if (!i_rst_n) begin
      data_d <= '0;
      de_d <= 1'b0;
      vsync_d <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      part <= '0;
      sof_arm <= 1'b0;
      lcnt <= '0;
      o_line_pix <= '0;
      o_ovf <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      data_d <= i_data;
      de_d <= i_de;
      vsync_d <= i_vsync;
      o_ovf <= drop | (o_ovf & ~i_ovf_clr);
      lcnt <= vs_rise | last ? '0 : de_d ? lnext : lcnt;
      if (last & ~vs_rise) o_line_pix <= lnext;
      if (vs_rise) begin
        state <= ACTIVE;
        cnt <= '0;
        sof_arm <= 1'b1;
      end else if (state == ACTIVE & de_d) begin
        part[16*cnt +: 16] <= data_d;
        cnt <= push_req ? '0 : cnt + 2'd1;
        sof_arm <= sof_arm & ~push;
        state <= drop ? DROP : ACTIVE;
      end
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: tb/tb_yuv422_pack64.sv
// tb_yuv422_pack64: randomized/directed bench with a pixel-queue reference model and
// literal expectations for the directed scenarios.
module tb_yuv422_pack64;
  localparam int D = 8;
  localparam logic [15:0] PAD = 16'h1080;
  logic i_sclk = 0, i_rst_n = 0;
  logic [15:0] i_data = 0;
  logic i_vsync = 0, i_hsync = 0, i_de = 0, i_wready = 0, i_ovf_clr = 0;
  logic [63:0] o_wdata;
  logic o_sof, o_eol, o_wvalid, o_ovf;
  logic [11:0] o_line_pix;
  always #5 i_sclk = ~i_sclk;

  yuv422_pack64 #(.P_FIFO_DEPTH(D), .P_PAD(PAD)) dut (
    .i_sclk(i_sclk), .i_rst_n(i_rst_n), .i_data(i_data), .i_vsync(i_vsync),
    .i_hsync(i_hsync), .i_de(i_de), .o_wdata(o_wdata), .o_sof(o_sof), .o_eol(o_eol),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_ovf(o_ovf), .i_ovf_clr(i_ovf_clr),
    .o_line_pix(o_line_pix)
  );

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: pixels gathered per word, words queued, one cycle of input history
  logic [65:0] q[$], got[$];
  logic [15:0] pend[$];
  logic m_sof_arm = 0, m_active = 0, m_ovf = 0, p_de = 0, p_vs = 0, m_pop, m_full, m_set;
  logic [15:0] p_data = 0;
  logic [63:0] m_w;
  int lc = 0, m_line = 0;
  always @(posedge i_sclk) begin
    if (o_wvalid && i_wready) got.push_back({o_sof, o_eol, o_wdata});
    if (!i_rst_n) begin
      q.delete(); pend.delete();
      m_sof_arm = 0; m_active = 0; m_ovf = 0; p_de = 0; p_vs = 0; lc = 0; m_line = 0;
    end else begin
      m_pop = q.size() > 0 && i_wready;
      m_full = q.size() == D;
      m_set = 0;
      if (m_pop) void'(q.pop_front());
      if (i_vsync && !p_vs) begin
        pend.delete(); m_sof_arm = 1; m_active = 1; lc = 0;
      end else if (p_de) begin
        lc = lc < 4095 ? lc + 1 : 4095;
        if (!i_de) begin m_line = lc; lc = 0; end
        if (m_active) begin
          pend.push_back(p_data);
          if (pend.size() == 4 || !i_de) begin
            m_w = {4{PAD}};
            for (int i = 0; i < pend.size(); i++) m_w[16*i +: 16] = pend[i];
            if (m_full && !m_pop) begin m_set = 1; m_active = 0; end
            else begin q.push_back({m_sof_arm, !i_de, m_w}); m_sof_arm = 0; end
            pend.delete();
          end
        end
      end
      m_ovf = m_set ? 1'b1 : i_ovf_clr ? 1'b0 : m_ovf;
      p_de = i_de; p_vs = i_vsync; p_data = i_data;
    end
  end

  always @(negedge i_sclk) if (i_rst_n) begin
    check("wvalid", 66'(o_wvalid), 66'(q.size() > 0));
    if (o_wvalid && q.size() > 0) check("head_word", {o_sof, o_eol, o_wdata}, q[0]);
    check("ovf", 66'(o_ovf), 66'(m_ovf));
    check("line_pix", 66'(o_line_pix), 66'(m_line));
  end

  logic rnd = 0;
  task automatic cyc(input logic de, input logic [15:0] d, input logic vs = 1'b0);
    @(negedge i_sclk);
    i_de = de; i_data = d; i_vsync = vs;
    if (rnd) i_wready = 1'($urandom_range(0, 1));
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0);
  endtask
  task automatic vsync_pulse();
    cyc(0, 0, 1); idle(2);
  endtask
  task automatic line(input logic [15:0] base, input int n);
    i_hsync = 1; cyc(0, 0); i_hsync = 0;
    for (int i = 0; i < n; i++) cyc(1, base + 16'(i));
    cyc(0, 0);
  endtask

  int g, bad, eols;
  logic [15:0] k;
  logic [65:0] e;
  initial begin
    idle(3);
    i_rst_n = 1;
    idle(1);
    check("rst_wvalid", 66'(o_wvalid), 66'(0));
    check("rst_ovf", 66'(o_ovf), 66'(0));
    check("rst_line_pix", 66'(o_line_pix), 66'(0));
    // 8-pixel line
    i_wready = 1;
    vsync_pulse();
    g = got.size();
    line(16'h0001, 8); idle(4);
    check("l8_w0", got[g], {2'b10, 64'h0004_0003_0002_0001});
    check("l8_w1", got[g+1], {2'b01, 64'h0008_0007_0006_0005});
    check("l8_pix", 66'(o_line_pix), 66'(8));
    // 6-pixel line with padding
    g = got.size();
    line(16'hA001, 6); idle(4);
    check("l6_w0", got[g], {2'b00, 64'hA004_A003_A002_A001});
    check("l6_w1", got[g+1], {2'b01, 64'h1080_1080_A006_A005});
    check("l6_pix", 66'(o_line_pix), 66'(6));
    // overflow with consumer stalled
    i_wready = 0;
    vsync_pulse();
    line(16'h0100, 64); idle(2); line(16'h0200, 64); idle(4);
    check("ovf_set", 66'(o_ovf), 66'(1));
    // new overflow coincides with a clear pulse: set wins
    vsync_pulse();
    for (int i = 0; i < 4; i++) cyc(1, 16'h0300 + 16'(i));
    cyc(0, 0); i_ovf_clr = 1;
    cyc(0, 0); i_ovf_clr = 0;
    idle(2);
    check("ovf_set_wins", 66'(o_ovf), 66'(1));
    cyc(0, 0); i_ovf_clr = 1;
    cyc(0, 0); i_ovf_clr = 0;
    idle(1);
    check("ovf_cleared", 66'(o_ovf), 66'(0));
    g = got.size();
    i_wready = 1;
    idle(20);
    check("ovf_drain_cnt", 66'(got.size() - g), 66'(8));
    check("ovf_drain_sof", 66'(got[g][65]), 66'(1));
    vsync_pulse();
    g = got.size();
    line(16'h0400, 4); idle(4);
    check("after_ovf_w0", got[g], {2'b11, 64'h0403_0402_0401_0400});
    // vsync cuts a line after 3 pixels
    g = got.size();
    for (int i = 0; i < 3; i++) cyc(1, 16'h0500 + 16'(i));
    cyc(0, 0, 1); idle(3);
    check("cut_nopush", 66'(got.size() - g), 66'(0));
    line(16'hB001, 4); idle(4);
    check("cut_w0", got[g], {2'b11, 64'hB004_B003_B002_B001});
    check("cut_cnt", 66'(got.size() - g), 66'(1));
    // 1920x4 frame with random backpressure
    rnd = 1;
    vsync_pulse();
    g = got.size();
    k = 0;
    for (int l = 0; l < 4; l++) begin
      i_hsync = 1; cyc(0, 0); i_hsync = 0;
      for (int i = 0; i < 1920; i++) begin cyc(1, k); k++; end
      idle(8);
    end
    rnd = 0; i_wready = 1;
    idle(30);
    check("frame_words", 66'(got.size() - g), 66'(1920));
    bad = 0; eols = 0;
    for (int i = 0; i < 1920 && g + i < got.size(); i++) begin
      e = {i == 0, (i % 480) == 479, 16'(4*i+3), 16'(4*i+2), 16'(4*i+1), 16'(4*i)};
      if (got[g+i] !== e) bad++;
      if (got[g+i][64]) eols++;
    end
    check("frame_order", 66'(bad), 66'(0));
    check("frame_eols", 66'(eols), 66'(4));
    check("frame_pix", 66'(o_line_pix), 66'(1920));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
